// File: rtl/pf_lanectrl_pause_gen.sv
// Pause sequencer for the lane controller: brackets each IOD delay-tap update with
// HS_IO_CLK_PAUSE, issues the requested DELAY_MOVE strobes and enforces a release gap.
module pf_lanectrl_pause_gen #(
  parameter int PRE_CYCLES  = 2,
  parameter int POST_CYCLES = 4,
  parameter int GAP_CYCLES  = 3,
  parameter int MOVE_W      = 4
) (
  input  logic              CLK,
  input  logic              ARST_N,
  input  logic              REQ,
  input  logic              REQ_DIR,
  input  logic [MOVE_W-1:0] REQ_MOVES,
  output logic              BUSY,
  output logic              ACK,
  output logic              HS_IO_CLK_PAUSE,
  output logic              DELAY_MOVE,
  output logic              DELAY_DIRECTION
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_MOVE, S_POST, S_REL, S_GAP, S_ACKZ
  } state_t;

  localparam logic [3:0] PRE_LD  = 4'(PRE_CYCLES - 1);
  localparam logic [3:0] POST_LD = 4'(POST_CYCLES - 1);
  localparam logic [3:0] GAP_LD  = 4'(GAP_CYCLES - 1);

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic [MOVE_W-1:0] moves_reg;

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= '0;
      moves_reg       <= '0;
      BUSY            <= 1'b0;
      ACK             <= 1'b0;
      HS_IO_CLK_PAUSE <= 1'b0;
      DELAY_MOVE      <= 1'b0;
      DELAY_DIRECTION <= 1'b0;
    end else begin
      ACK        <= 1'b0;
      DELAY_MOVE <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (REQ) begin
            DELAY_DIRECTION <= REQ_DIR;
            moves_reg       <= REQ_MOVES;
            BUSY            <= 1'b1;
            if (REQ_MOVES != '0) begin
              state_reg       <= S_PRE;
              HS_IO_CLK_PAUSE <= 1'b1;
              cnt_reg         <= PRE_LD;
            end else begin
              state_reg <= S_ACKZ;
              ACK       <= 1'b1;
            end
          end
        end
        S_PRE: begin
          if (cnt_reg == '0) begin
            state_reg  <= S_MOVE;
            DELAY_MOVE <= 1'b1;
            moves_reg  <= moves_reg - 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_MOVE: begin
          // moves_reg counts strobes still to issue, so it reaches zero without wrapping
          if (DELAY_MOVE) begin
            if (moves_reg == '0) begin
              state_reg <= S_POST;
              cnt_reg   <= POST_LD;
            end
          end else begin
            DELAY_MOVE <= 1'b1;
            moves_reg  <= moves_reg - 1'b1;
          end
        end
        S_POST: begin
          if (cnt_reg == '0) begin
            state_reg       <= S_REL;
            HS_IO_CLK_PAUSE <= 1'b0;
            ACK             <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_REL: begin
          state_reg <= S_GAP;
          cnt_reg   <= GAP_LD;
        end
        S_GAP: begin
          if (cnt_reg == '0) begin
            state_reg <= S_IDLE;
            BUSY      <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_ACKZ: begin
          state_reg <= S_IDLE;
          BUSY      <= 1'b0;
        end
        default: begin
          state_reg       <= S_IDLE;
          BUSY            <= 1'b0;
          HS_IO_CLK_PAUSE <= 1'b0;
        end
      endcase
    end
  end

endmodule
